// File: rtl/mem_port_arbiter.sv
// Shares the data-memory port between instruction fetch and the load/store unit.
// Define MEM_ARB_ROUND_ROBIN_EN to resolve ties round-robin instead of data-first.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_grant,
   output logic              if_done,
   input  logic              d_req,
   input  logic              d_is_store,
   input  logic [1:0]        d_word_type,
   input  logic              d_is_signed,
   input  logic [ADDR_W-1:0] d_addr,
   output logic              d_grant,
   output logic              d_done,
   output logic              err,
   output logic              busy,
   output logic              mc_load,
   output logic              mc_store,
   output logic [1:0]        mc_word_type,
   output logic              mc_is_signed,
   output logic [ADDR_W-1:0] mc_addr,
   input  logic              mc_output_valid,
   input  logic              mc_write_ready
);

   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [1:0] WT_WORD    = 2'b10;
   localparam logic [1:0] WT_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

   state_t          state;
   logic [WD_W-1:0] watchdog;
   logic            owner_d;
   logic            last_owner_d;
   logic            is_store_q;
   logic            illegal_q;
   logic            pick_d;
   logic            complete;
   logic            wd_expired;

   assign busy       = (state != ST_IDLE);
   assign complete   = is_store_q ? mc_write_ready : mc_output_valid;
   assign wd_expired = (watchdog == WD_W'(TIMEOUT - 1));

   always_comb begin
      pick_d = d_req;
      if (d_req && if_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         pick_d = !last_owner_d;
`else
         pick_d = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         watchdog     <= '0;
         owner_d      <= 1'b0;
         last_owner_d <= 1'b0;
         is_store_q   <= 1'b0;
         illegal_q    <= 1'b0;
         if_grant     <= 1'b0;
         d_grant      <= 1'b0;
         if_done      <= 1'b0;
         d_done       <= 1'b0;
         err          <= 1'b0;
         mc_load      <= 1'b0;
         mc_store     <= 1'b0;
         mc_word_type <= 2'b00;
         mc_is_signed <= 1'b0;
         mc_addr      <= '0;
      end else begin
         if_grant <= 1'b0;
         d_grant  <= 1'b0;
         if_done  <= 1'b0;
         d_done   <= 1'b0;
         err      <= 1'b0;
         mc_load  <= 1'b0;
         mc_store <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (if_req || d_req) begin
                  state    <= ST_ISSUE;
                  watchdog <= '0;
                  owner_d  <= pick_d;
                  if (pick_d) begin
                     d_grant      <= 1'b1;
                     mc_addr      <= d_addr;
                     mc_word_type <= d_word_type;
                     mc_is_signed <= d_is_signed;
                     is_store_q   <= d_is_store;
                     illegal_q    <= (d_word_type == WT_ILLEGAL);
                     if (d_word_type != WT_ILLEGAL) begin
                        mc_store <= d_is_store;
                        mc_load  <= !d_is_store;
                     end
                  end else begin
                     // Fetch is always an unsigned word load.
                     if_grant     <= 1'b1;
                     mc_addr      <= if_addr;
                     mc_word_type <= WT_WORD;
                     mc_is_signed <= 1'b0;
                     is_store_q   <= 1'b0;
                     illegal_q    <= 1'b0;
                     mc_load      <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               // An illegal width skips the controller entirely.
               if (illegal_q) begin
                  state   <= ST_DONE;
                  if_done <= !owner_d;
                  d_done  <= owner_d;
                  err     <= 1'b1;
               end else begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (complete) begin
                  state   <= ST_DONE;
                  if_done <= !owner_d;
                  d_done  <= owner_d;
               end else if (wd_expired) begin
                  state   <= ST_DONE;
                  if_done <= !owner_d;
                  d_done  <= owner_d;
                  err     <= 1'b1;
               end else begin
                  watchdog <= watchdog + WD_W'(1);
               end
            end
            ST_DONE: begin
               last_owner_d <= owner_d;
               state        <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single data-memory port between instruction fetch and the load/store unit, and sequences `memory_control_fsm` on behalf of the winner. It sits between the two requesters and the memory controller:

- accepts one request at a time;
- issues a one-cycle `load`/`store` command with latched address and width;
- waits for the controller's completion strobe (`output_valid` or `write_ready`);
- returns a done pulse to the owning requester.

A watchdog and word-type check prevent a hung or malformed access from locking the port.

## Interface
- `ADDR_W`, 32, address width of both requesters and of the controller address.
- `TIMEOUT`, 15, maximum WAIT cycles before the access is aborted (must be ≥ 4).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; hold until `if_grant`.
- `if_addr`  in  ADDR_W  fetch address; sampled at grant.
- `if_grant`  out  1  one-cycle pulse: fetch request accepted.
- `if_done`  out  1  one-cycle pulse: fetch access finished.
- `d_req`  in  1  load/store request; hold until `d_grant`.
- `d_is_store`  in  1  1 = store, 0 = load.
- `d_word_type`  in  2  2'b10 word, 2'b01 halfword, 2'b00 byte; 2'b11 illegal.
- `d_is_signed`  in  1  sign-extend on load.
- `d_addr`  in  ADDR_W  data address; sampled at grant.
- `d_grant`  out  1  one-cycle pulse: data request accepted.
- `d_done`  out  1  one-cycle pulse: data access finished.
- `err`  out  1  one-cycle pulse coincident with done: timeout or illegal word type.
- `busy`  out  1  high in every state except IDLE.
- `mc_load`, `mc_store`  out  1  controller command; one-cycle pulse.
- `mc_word_type`  out  2  latched width to controller.
- `mc_is_signed`  out  1  latched sign flag to controller.
- `mc_addr`  out  ADDR_W  latched address to controller; stable from ISSUE through DONE.
- `mc_output_valid`  in  1  controller load completion.
- `mc_write_ready`  in  1  controller store completion.

## Operation

**Reset**
- All outputs are 0.
- State = IDLE; watchdog = 0.
- `last_owner` = fetch.
- Reset mid-access abandons the access without a done pulse.

**States**
- IDLE:
  - with no request, remain in IDLE;
  - on a request, select the winner, latch its fields, register the grant pulse, set `mc_load`/`mc_store` and go to ISSUE.
- Fetch requests are always translated to word_type 2'b10, is_signed 0, load.
- Illegal data word type 2'b11:
  - grant is given but no `mc_load`/`mc_store` is issued;
  - go directly to DONE with `err` = 1.
- ISSUE (exactly one cycle): command pulse visible; go to WAIT; `mc_load`/`mc_store` clear at exit.
- WAIT:
  - a load completes on `mc_output_valid`, a store on `mc_write_ready`;
  - the other strobe is ignored;
  - on completion, register the owner's done and go to DONE;
  - the watchdog increments each WAIT cycle and reaches TIMEOUT−1 without completion; at that point, register done plus `err` and go to DONE.
- DONE (one cycle): done/`err` visible, `last_owner` updated; return to IDLE.
  - A new request is not arbitrated in DONE.

**Requests**
- A requester may drop its request before grant without side effects.
- Request inputs are ignored while `busy`.

## Timing
- Request seen in IDLE cycle N:
  - grant and `mc_load`/`mc_store` high in N+1 (ISSUE);
  - WAIT from N+2.
- Completion strobe in cycle M: done high in M+1; IDLE in M+2.
- Next grant no earlier than M+3.
- Minimum turnaround for a halfword load: request N → done N+3.
- Word load (two controller cycles): done N+4.
- Illegal word type: grant N+1, done+`err` N+2.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` undefined: fixed priority; `d_req` always wins a tie with `if_req`.
- `MEM_ARB_ROUND_ROBIN_EN` defined: on a tie, the requester other than `last_owner` wins. `last_owner` is reset to fetch, so the first tie goes to data.
- Non-tie behaviour is identical in both builds.

## Test plan
- Fetch only: `if_req`=1, `if_addr`=0x100 in cycle 0 → `if_grant` cycle 1, `mc_load`=1, `mc_word_type`=2'b10, `mc_addr`=0x100; controller `mc_output_valid` in cycle 3 → `if_done` cycle 4, `busy`=0 cycle 5.
- Signed byte store: `d_req`, `d_is_store`=1, `d_word_type`=2'b00, `d_addr`=0x2A → `mc_store` one cycle only; `mc_output_valid` during WAIT ignored; `mc_write_ready` → `d_done` next cycle, `err`=0.
- Tie, `if_req`=`d_req`=1 held across two accesses:
  - fixed build: `d_grant` both times;
  - RR build: `d_grant` first, `if_grant` second.
- Timeout: grant a load, never assert completion → `d_done`=`err`=1 exactly TIMEOUT cycles after WAIT entry (15 with default); IDLE after the following cycle.
- Illegal type: `d_word_type`=2'b11 → `d_grant`, no `mc_load`/`mc_store`, `d_done`=`err`=1 one cycle later.
- Reset in WAIT: drop `reset` low → all outputs 0 asynchronously, no done pulse; after release, a new `if_req` is granted normally.
